// File: rtl/adxl362_pkg.sv
// Shared encodings for the ADXL362 sample FIFO.
//   FIFO_MODE_*       : values of the 2-bit fifo_mode input.
//   ARMED/CAPTURE/DONE: triggered-mode capture states. They are only used
//                       when ADXL362_FIFO_TRIGGER_EN is defined.
package adxl362_pkg;

    localparam logic [1:0] FIFO_MODE_DISABLED = 2'b00;
    localparam logic [1:0] FIFO_MODE_OLDEST   = 2'b01;
    localparam logic [1:0] FIFO_MODE_STREAM   = 2'b10;
    localparam logic [1:0] FIFO_MODE_TRIGGER  = 2'b11;

    localparam logic [1:0] ARMED   = 2'd0;
    localparam logic [1:0] CAPTURE = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

endpackage

// File: rtl/adxl362_fifo_mem.sv
// Simple dual-port sample store for the ADXL362 FIFO.
// There is one synchronous write port and one registered read port.
// The array itself is never reset. Only the read-data register resets to 0.
// When a read and a write hit the same address, the read returns the old word.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset (read register only)
//   we, waddr, wdata  : write port
//   re, raddr         : read enable/address; rdata loads on re, otherwise holds
//   rdata             : registered read data
module adxl362_fifo_mem #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 512,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/adxl362_sample_fifo.sv
// Parametrised sample FIFO for the ADXL362 behavioural model.
// It supports the modes disabled, oldest-saved, stream and triggered.
// It also has a programmable watermark and a sticky overrun flag.
// Optional feature macro: ADXL362_FIFO_TRIGGER_EN. When it is undefined, mode 11
// behaves as stream, trigger is ignored and trig_done is 0.
// Ports:
//   clk_16mhz, rst        : clock, asynchronous active-high reset
//   fifo_mode, watermark  : mode select, watermark / pre-trigger retention count
//   flush, trigger        : synchronous clear, single-cycle trigger event
//   write, data_write     : writer side
//   read, data_read       : reader side (data_read has 1-cycle latency)
//   count, full, empty, watermark_hit, overrun, trig_done : registered status
module adxl362_sample_fifo
    import adxl362_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int DEPTH      = 512,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk_16mhz,
    input  logic                  rst,
    input  logic [1:0]            fifo_mode,
    input  logic [AW:0]           watermark,
    input  logic                  flush,
    input  logic                  trigger,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] data_write,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] data_read,
    output logic [AW:0]           count,
    output logic                  full,
    output logic                  empty,
    output logic                  watermark_hit,
    output logic                  overrun,
    output logic                  trig_done
);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_addr;
    logic [AW:0]   count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          full_q, empty_q, wm_hit_q;
    logic [1:0]    mode_q;
    logic          mem_we, mem_re;
    logic          wr_allowed, stream_wr, capture_wr;

`ifdef ADXL362_FIFO_TRIGGER_EN
    logic [1:0]    state_q, state_d;
`else
    logic          unused_trigger;
    assign unused_trigger = trigger;
`endif

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overrun_d  = overrun_q;
        rd_addr    = rd_ptr_q;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        wr_allowed = 1'b0;
        stream_wr  = 1'b0;
        capture_wr = 1'b0;
`ifdef ADXL362_FIFO_TRIGGER_EN
        state_d    = state_q;
`endif
        if (flush || (fifo_mode != mode_q)) begin
            // On a flush or mode change, clear state and drop this cycle's strobes.
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            count_d   = '0;
            overrun_d = 1'b0;
`ifdef ADXL362_FIFO_TRIGGER_EN
            state_d   = ARMED;
`endif
        end else begin
            case (fifo_mode)
                FIFO_MODE_DISABLED: wr_allowed = 1'b0;
                FIFO_MODE_OLDEST:   wr_allowed = 1'b1;
                FIFO_MODE_STREAM: begin
                    wr_allowed = 1'b1;
                    stream_wr  = 1'b1;
                end
                default: begin
`ifdef ADXL362_FIFO_TRIGGER_EN
                    // On trigger, keep only the newest 'watermark' samples.
                    // Any read or write in this cycle applies after the trim.
                    if ((state_q == ARMED) && trigger) begin
                        if (count_q > watermark) begin
                            rd_ptr_d = wr_ptr_q - watermark[AW-1:0];
                            count_d  = watermark;
                        end
                        state_d = CAPTURE;
                    end
                    wr_allowed = (state_d != DONE);
                    stream_wr  = (state_d == ARMED);
                    capture_wr = (state_d == CAPTURE);
`else
                    wr_allowed = 1'b1;
                    stream_wr  = 1'b1;
`endif
                end
            endcase

            // The read is evaluated first, so a full FIFO that reads and
            // writes in the same cycle also accepts the write.
            rd_addr = rd_ptr_d;
            if (read && (count_d != '0)) begin
                mem_re   = 1'b1;
                rd_ptr_d = rd_ptr_d + PTR_ONE;
                count_d  = count_d - CNT_ONE;
            end

            if (write && wr_allowed) begin
                if (count_d != CNT_FULL) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    count_d  = count_d + CNT_ONE;
                end else if (stream_wr) begin
                    // Overwrite the oldest word; wr and rd pointers move together.
                    mem_we    = 1'b1;
                    wr_ptr_d  = wr_ptr_q + PTR_ONE;
                    rd_ptr_d  = rd_ptr_d + PTR_ONE;
                    overrun_d = 1'b1;
                end else if (capture_wr) begin
                    // In capture, the first dropped sample ends the capture
                    // without flagging overrun.
`ifdef ADXL362_FIFO_TRIGGER_EN
                    state_d = DONE;
`endif
                end else begin
                    overrun_d = 1'b1;
                end
            end

`ifdef ADXL362_FIFO_TRIGGER_EN
            if ((state_d == CAPTURE) && (count_d == CNT_FULL)) begin
                state_d = DONE;
            end
`endif
        end
    end

    always_ff @(posedge clk_16mhz or posedge rst) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            wm_hit_q  <= 1'b0;
            mode_q    <= FIFO_MODE_DISABLED;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            full_q    <= (count_d == CNT_FULL);
            empty_q   <= (count_d == '0);
            wm_hit_q  <= (watermark != '0) && (count_d >= watermark);
            mode_q    <= fifo_mode;
        end
    end

`ifdef ADXL362_FIFO_TRIGGER_EN
    always_ff @(posedge clk_16mhz or posedge rst) begin
        if (rst) begin
            state_q <= ARMED;
        end else begin
            state_q <= state_d;
        end
    end
    assign trig_done = (state_q == DONE);
`else
    assign trig_done = 1'b0;
`endif

    adxl362_fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .AW        (AW)
    ) u_mem (
        .clk  (clk_16mhz),
        .rst  (rst),
        .we   (mem_we),
        .waddr(wr_ptr_q),
        .wdata(data_write),
        .re   (mem_re),
        .raddr(rd_addr),
        .rdata(data_read)
    );

    assign count         = count_q;
    assign full          = full_q;
    assign empty         = empty_q;
    assign watermark_hit = wm_hit_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_adxl362_sample_fifo.sv
module tb_adxl362_sample_fifo;

    logic        clk_16mhz = 1'b0;
    logic        rst;
    logic [1:0]  fifo_mode;
    logic [3:0]  watermark;
    logic        flush, trigger, write, read;
    logic [15:0] data_write, data_read;
    logic [3:0]  count;
    logic        full, empty, watermark_hit, overrun, trig_done;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic        wr;
        logic        rd;
        logic [15:0] din;
        logic [3:0]  e_count;
        logic        e_full;
        logic        e_wm;
        logic        e_ovr;
        logic [15:0] e_rdata;
    } vec_t;
    vec_t vecs[11];

    adxl362_sample_fifo #(.DATA_WIDTH(16), .DEPTH(8)) dut (
        .clk_16mhz    (clk_16mhz),
        .rst          (rst),
        .fifo_mode    (fifo_mode),
        .watermark    (watermark),
        .flush        (flush),
        .trigger      (trigger),
        .write        (write),
        .data_write   (data_write),
        .read         (read),
        .data_read    (data_read),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .watermark_hit(watermark_hit),
        .overrun      (overrun),
        .trig_done    (trig_done)
    );

    always #31 clk_16mhz = ~clk_16mhz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic cycle(input logic wr, input logic rd, input logic [15:0] din, input logic trig);
        write      = wr;
        read       = rd;
        data_write = din;
        trigger    = trig;
        @(posedge clk_16mhz);
        #1;
        write   = 1'b0;
        read    = 1'b0;
        trigger = 1'b0;
    endtask

    task automatic set_mode(input logic [1:0] m);
        fifo_mode = m;
        cycle(1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic read_chk(input string name);
        logic [15:0] e;
        cycle(1'b0, 1'b1, 16'h0, 1'b0);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s actual=%0h expected=<none queued>", name, data_read);
        end else begin
            e = exp_q.pop_front();
            check(name, 32'(data_read), 32'(e));
        end
    endtask

    task automatic check_reset_flags(input string tag);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_empty"}, 32'(empty), 32'd1);
        check({tag, "_full"}, 32'(full), 32'd0);
        check({tag, "_wm"}, 32'(watermark_hit), 32'd0);
        check({tag, "_ovr"}, 32'(overrun), 32'd0);
        check({tag, "_trig"}, 32'(trig_done), 32'd0);
    endtask

    initial begin
        // Watermark = 4 in mode 01, then a full FIFO with a simultaneous read and write.
        vecs[0]  = '{1'b1, 1'b0, 16'h0011, 4'd1, 1'b0, 1'b0, 1'b0, 16'h0};
        vecs[1]  = '{1'b1, 1'b0, 16'h0012, 4'd2, 1'b0, 1'b0, 1'b0, 16'h0};
        vecs[2]  = '{1'b1, 1'b0, 16'h0013, 4'd3, 1'b0, 1'b0, 1'b0, 16'h0};
        vecs[3]  = '{1'b1, 1'b0, 16'h0014, 4'd4, 1'b0, 1'b1, 1'b0, 16'h0};
        vecs[4]  = '{1'b0, 1'b1, 16'h0000, 4'd3, 1'b0, 1'b0, 1'b0, 16'h0011};
        vecs[5]  = '{1'b1, 1'b0, 16'h0015, 4'd4, 1'b0, 1'b1, 1'b0, 16'h0};
        vecs[6]  = '{1'b1, 1'b0, 16'h0016, 4'd5, 1'b0, 1'b1, 1'b0, 16'h0};
        vecs[7]  = '{1'b1, 1'b0, 16'h0017, 4'd6, 1'b0, 1'b1, 1'b0, 16'h0};
        vecs[8]  = '{1'b1, 1'b0, 16'h0018, 4'd7, 1'b0, 1'b1, 1'b0, 16'h0};
        vecs[9]  = '{1'b1, 1'b0, 16'h0019, 4'd8, 1'b1, 1'b1, 1'b0, 16'h0};
        vecs[10] = '{1'b1, 1'b1, 16'h00AA, 4'd8, 1'b1, 1'b1, 1'b0, 16'h0012};

        rst = 1'b1; fifo_mode = 2'b00; watermark = 4'd0; flush = 1'b0;
        trigger = 1'b0; write = 1'b0; read = 1'b0; data_write = 16'h0;
        repeat (2) @(posedge clk_16mhz);
        #1;
        check("rst_data", 32'(data_read), 32'd0);
        check_reset_flags("rst");
        rst = 1'b0;

        // Mode 00: writes are ignored.
        cycle(1'b1, 1'b0, 16'h1234, 1'b0);
        check("dis_empty", 32'(empty), 32'd1);
        check("dis_count", 32'(count), 32'd0);

        // Mode 01: oldest-saved.
        set_mode(2'b01);
        for (int i = 1; i <= 10; i++) cycle(1'b1, 1'b0, 16'(i), 1'b0);
        check("m01_count", 32'(count), 32'd8);
        check("m01_full", 32'(full), 32'd1);
        check("m01_ovr", 32'(overrun), 32'd1);
        for (int i = 1; i <= 8; i++) exp_q.push_back(16'(i));
        for (int i = 0; i < 8; i++) read_chk("m01_rd");
        check("m01_empty", 32'(empty), 32'd1);
        check("m01_ovr_end", 32'(overrun), 32'd1);

        // Mode 10: stream.
        set_mode(2'b10);
        check("m10_clr_ovr", 32'(overrun), 32'd0);
        for (int i = 1; i <= 10; i++) cycle(1'b1, 1'b0, 16'(i), 1'b0);
        check("m10_count", 32'(count), 32'd8);
        for (int i = 3; i <= 10; i++) exp_q.push_back(16'(i));
        for (int i = 0; i < 8; i++) read_chk("m10_rd");
        check("m10_ovr", 32'(overrun), 32'd1);
        check("m10_empty", 32'(empty), 32'd1);

        // Mode 11: triggered, watermark 3.
        watermark = 4'd3;
        set_mode(2'b11);
        for (int i = 1; i <= 6; i++) cycle(1'b1, 1'b0, 16'(i), 1'b0);
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
`ifdef ADXL362_FIFO_TRIGGER_EN
        check("m11_trim_count", 32'(count), 32'd3);
        for (int i = 7; i <= 16; i++) begin
            cycle(1'b1, 1'b0, 16'(i), 1'b0);
            if (i == 11) check("m11_done_at_full", 32'(trig_done), 32'd1);
        end
        check("m11_count", 32'(count), 32'd8);
        check("m11_ovr", 32'(overrun), 32'd0);
        for (int i = 4; i <= 11; i++) exp_q.push_back(16'(i));
`else
        for (int i = 7; i <= 16; i++) cycle(1'b1, 1'b0, 16'(i), 1'b0);
        check("m11_count", 32'(count), 32'd8);
        check("m11_ovr", 32'(overrun), 32'd1);
        check("m11_trig", 32'(trig_done), 32'd0);
        for (int i = 9; i <= 16; i++) exp_q.push_back(16'(i));
`endif
        for (int i = 0; i < 8; i++) read_chk("m11_rd");

        // Table-driven vectors: watermark hit and a full simultaneous read/write.
        watermark = 4'd4;
        set_mode(2'b01);
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].rd) exp_q.push_back(vecs[i].e_rdata);
            cycle(vecs[i].wr, vecs[i].rd, vecs[i].din, 1'b0);
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_count));
            check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].e_full));
            check($sformatf("vec%0d_wm", i), 32'(watermark_hit), 32'(vecs[i].e_wm));
            check($sformatf("vec%0d_ovr", i), 32'(overrun), 32'(vecs[i].e_ovr));
            if (vecs[i].rd) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL vec%0d_rd actual=%0h expected=<none queued>", i, data_read);
                end else begin
                    check($sformatf("vec%0d_rd", i), 32'(data_read), 32'(exp_q.pop_front()));
                end
            end
        end
        for (int i = 8'h13; i <= 8'h19; i++) exp_q.push_back(16'(i));
        exp_q.push_back(16'h00AA);
        for (int i = 0; i < 8; i++) read_chk("full_rw_rd");
        check("full_rw_empty", 32'(empty), 32'd1);

        // Reset mid-fill.
        for (int i = 1; i <= 5; i++) cycle(1'b1, 1'b0, 16'(8'h40 + i), 1'b0);
        check("midrst_pre_count", 32'(count), 32'd5);
        rst = 1'b1;
        #2;
        check("midrst_data", 32'(data_read), 32'd0);
        check_reset_flags("midrst");
        @(posedge clk_16mhz);
        #1;
        rst = 1'b0;
        cycle(1'b0, 1'b1, 16'h0, 1'b0);
        check("midrst_rd_empty", 32'(empty), 32'd1);
        check("midrst_rd_data", 32'(data_read), 32'd0);

        // Mode change mid-fill.
        set_mode(2'b01);
        cycle(1'b1, 1'b0, 16'h0055, 1'b0);
        exp_q.push_back(16'h0055);
        read_chk("mchg_seed_rd");
        for (int i = 1; i <= 5; i++) cycle(1'b1, 1'b0, 16'(8'h60 + i), 1'b0);
        check("mchg_pre_count", 32'(count), 32'd5);
        check("mchg_pre_wm", 32'(watermark_hit), 32'd1);
        set_mode(2'b10);
        check_reset_flags("mchg");
        cycle(1'b0, 1'b1, 16'h0, 1'b0);
        check("mchg_rd_empty", 32'(empty), 32'd1);
        check("mchg_rd_data", 32'(data_read), 32'h55);

        // Flush clears contents and sticky overrun.
        for (int i = 1; i <= 9; i++) cycle(1'b1, 1'b0, 16'(i), 1'b0);
        check("flush_pre_ovr", 32'(overrun), 32'd1);
        flush = 1'b1;
        cycle(1'b1, 1'b0, 16'h00EE, 1'b0);
        flush = 1'b0;
        check_reset_flags("flush");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
